// File: rtl/alu_shift_pkg.sv
// Shared definitions for the iterative shift/rotate engine.
// ALU_SHIFT_STEP4_EN selects a 4-bit-per-cycle step; otherwise one bit per cycle.
package alu_shift_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned B_W    = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned K_W    = 3;

`ifdef ALU_SHIFT_STEP4_EN
    localparam int unsigned MAX_STEP = 4;
`else
    localparam int unsigned MAX_STEP = 1;
`endif

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encodings above ROL are pass-through.
    function automatic logic is_shift_op(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single step: shifts or rotates a value by k bits (1..MAX_STEP).
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [2:0]       op_i,
    input  logic [K_W-1:0]   k_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = value_i;
        case (op_i)
            OP_SHR:  result_o = value_i >> k_i;
            OP_SHRA: result_o = $unsigned($signed(value_i) >>> k_i);
            OP_SHL:  result_o = value_i << k_i;
            OP_ROR:  result_o = (value_i >> k_i) | (value_i << (WIDTH - 32'(k_i)));
            OP_ROL:  result_o = (value_i << k_i) | (value_i >> (WIDTH - 32'(k_i)));
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate engine with start/done handshake feeding the Z register.
// Define ALU_SHIFT_STEP4_EN to retire up to 4 bits of the count per RUN cycle.
module alu_shift_seq
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   step_c;
    logic [WIDTH-1:0]   step_val_c;
    logic               unused_in_b;

    // Only the low count bits of the amount matter.
    assign unused_in_b = ^in_b[B_W-1:CNT_W];

    always_comb begin
`ifdef ALU_SHIFT_STEP4_EN
        step_c = (cnt_q < CNT_W'(MAX_STEP)) ? cnt_q : CNT_W'(MAX_STEP);
`else
        step_c = CNT_W'(1);
`endif
    end

    alu_shift_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .value_i (work_q),
        .op_i    (op_q),
        .k_i     (K_W'(step_c)),
        .result_o(step_val_c)
    );

    // Next-state, datapath updates; out is loaded only on entry to DONE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = in_a;
                    op_d   = op;
                    cnt_d  = in_b[CNT_W-1:0];
                    if (!is_shift_op(op) || (in_b[CNT_W-1:0] == '0)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                        out_d   = in_a;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d = step_val_c;
                cnt_d  = cnt_q - step_c;
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                    out_d   = step_val_c;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: whole-amount reference model plus directed vectors.
// Honours ALU_SHIFT_STEP4_EN for expected latencies.
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    int          m_left = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_out = 32'd0;

    alu_shift_seq dut (
        .clk  (clk),
        .clr_n(clr_n),
        .start(start),
        .op   (op),
        .in_a (in_a),
        .in_b (in_b),
        .busy (busy),
        .done (done),
        .out  (out)
    );

    always #5 clk = ~clk;

    // Full-amount result computed in one go.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input int n);
        logic [63:0] dbl;
        dbl = {a, a};
        case (o)
            3'd0: return a >> n;
            3'd1: return $unsigned($signed(a) >>> n);
            3'd2: return a << n;
            3'd3: return dbl[31:0] >> 0 == 0 ? (dbl >> n) : 32'((dbl >> n));
            3'd4: begin dbl = dbl << n; return dbl[63:32]; end
            default: return a;
        endcase
    endfunction

    // Busy cycles from accept to end of DONE (done appears in the last one).
    function automatic int exp_lat(input logic [2:0] o, input int n);
        if (o > 3'd4 || n == 0) return 1;
`ifdef ALU_SHIFT_STEP4_EN
        return (n + 3) / 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        int nl;
        if (!clr_n) begin
            m_left <= 0;
            m_res  <= 32'd0;
            m_out  <= 32'd0;
        end else if (m_left == 0) begin
            if (start) begin
                nl = exp_lat(op, int'(in_b[4:0]));
                m_left <= nl;
                m_res  <= ref_result(op, in_a, int'(in_b[4:0]));
                if (nl == 1) m_out <= ref_result(op, in_a, int'(in_b[4:0]));
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_out <= m_res;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("done", {31'd0, done}, {31'd0, m_left == 1});
            check("out", out, m_out);
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out, input int exp_edges);
        int lat;
        lat = 0;
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = i; break; end
        end
        check({name, "_out"}, out, exp_out);
        check({name, "_lat"}, 32'(lat), 32'(exp_edges));
    endtask

    initial begin
        int pulses;
        int lat;
        logic [31:0] first_out;

        #1;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out", out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #2 clr_n = 1'b1;

`ifdef ALU_SHIFT_STEP4_EN
        run_op("shr4", 3'd0, 32'h8000_00F0, 32'd4, 32'h0800_000F, 2);
`else
        run_op("shr4", 3'd0, 32'h8000_00F0, 32'd4, 32'h0800_000F, 5);
`endif
        run_op("shra31", 3'd1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, exp_lat(3'd1, 31));
        run_op("ror1", 3'd3, 32'h0000_0001, 32'd1, 32'h8000_0000, exp_lat(3'd3, 1));
        run_op("rol4", 3'd4, 32'h8000_0001, 32'd4, 32'h0000_0018, exp_lat(3'd4, 4));
        run_op("shl30", 3'd2, 32'h0000_0003, 32'd30, 32'hC000_0000, exp_lat(3'd2, 30));
        run_op("amt32", 3'd0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1);
        run_op("pass7", 3'd7, 32'h1234_5678, 32'd9, 32'h1234_5678, 1);
        run_op("hibits", 3'd2, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, exp_lat(3'd2, 3));

        // busy width for the long SHRA run
        @(negedge clk);
        start = 1'b1; op = 3'd1; in_a = 32'h8000_0000; in_b = 32'd31;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) lat++;
        end
        check("shra31_busy", 32'(lat), 32'(exp_lat(3'd1, 31)));

        // start re-pulsed mid-RUN is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd2; in_a = 32'h0000_0003; in_b = 32'd30;
        pulses = 0; first_out = 32'd0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin op = 3'd3; in_a = 32'hDEAD_BEEF; in_b = 32'd5; end
            if (done) begin
                if (pulses == 0) first_out = out;
                pulses++;
            end
        end
        check("midrun_pulses", 32'(pulses), 32'd1);
        check("midrun_out", first_out, 32'hC000_0000);

        // reset mid-RUN discards the op
        @(negedge clk);
        start = 1'b1; op = 3'd0; in_a = 32'hFFFF_0000; in_b = 32'd20;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 clr_n = 1'b0;
        @(negedge clk);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_out", out, 32'd0);
        #2 clr_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("clr_nodone", 32'(pulses), 32'd0);
        run_op("after_clr", 3'd4, 32'h0000_000F, 32'd28, 32'hF000_0000, exp_lat(3'd4, 28));

        // start held high: back-to-back ops
        @(negedge clk);
        start = 1'b1; op = 3'd4; in_a = 32'hA5A5_0001; in_b = 32'd7;
        for (int i = 0; i < 60; i++) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);

        // random traffic, start toggling freely
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            in_a  = $urandom;
            in_b  = $urandom;
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
